// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX controller between NUM_REQ byte-stream requesters.
// A grant lasts for a whole message and can prefix it with a {4'hA, id} source header byte.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_HEADER  = 1,
    parameter int GAP_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   i_Req_Valid,
    input  logic [8*NUM_REQ-1:0] i_Req_Byte,
    input  logic [NUM_REQ-1:0]   i_Req_Last,
    output logic [NUM_REQ-1:0]   o_Req_Ack,
    output logic [NUM_REQ-1:0]   o_Grant,
    output logic                 o_Tx_Ready,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic                 o_Abort
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_W'(GAP_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {IDLE, HDR_SEND, LOAD, SEND, WAIT} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    ptr_q;
    logic [GAP_W-1:0]   gap_q;
    logic               last_q;
    logic               done_q;
    logic               tx_ready_q;
    logic [7:0]         tx_byte_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               abort_q;

    logic [7:0]         req_byte [NUM_REQ];
    logic [ID_W-1:0]    pick_id;
    logic [ID_W-1:0]    scan_id;
    logic               pick_found;
    logic               done_rise;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]  = i_Req_Byte[8*gi +: 8];
            // Ack is combinational so the requester sees it in the very cycle its byte is captured.
            assign o_Req_Ack[gi] = (state_q == LOAD) && (id_q == ID_W'(gi)) && i_Req_Valid[gi];
        end
    endgenerate

    // Search ptr+1, ptr+2, ... with wrap; the first valid requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        scan_id    = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (scan_id == ID_W'(NUM_REQ - 1)) begin
                scan_id = '0;
            end else begin
                scan_id = scan_id + 1'b1;
            end
            if (!pick_found && i_Req_Valid[scan_id]) begin
                pick_found = 1'b1;
                pick_id    = scan_id;
            end
        end
    end

    assign done_rise  = i_Tx_Done & ~done_q;
    assign o_Grant    = grant_q;
    assign o_Tx_Ready = tx_ready_q;
    assign o_Tx_Byte  = tx_byte_q;
    assign o_Abort    = abort_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            id_q       <= '0;
            ptr_q      <= ID_W'(NUM_REQ - 1);
            gap_q      <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_byte_q  <= 8'h00;
            grant_q    <= '0;
            abort_q    <= 1'b0;
        end else begin
            done_q  <= i_Tx_Done;
            abort_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gap_q <= '0;
                    if (pick_found) begin
                        id_q    <= pick_id;
                        grant_q <= NUM_REQ'(1) << pick_id;
                        if (ADD_HEADER != 0) begin
                            tx_byte_q  <= {4'hA, 4'(pick_id)};
                            tx_ready_q <= 1'b1;
                            last_q     <= 1'b0;
                            state_q    <= HDR_SEND;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (i_Req_Valid[id_q]) begin
                        tx_byte_q  <= req_byte[id_q];
                        last_q     <= i_Req_Last[id_q];
                        tx_ready_q <= 1'b1;
                        gap_q      <= '0;
                        state_q    <= SEND;
                    end else if ((GAP_TIMEOUT != 0) && (gap_q == GAP_LAST)) begin
                        abort_q <= 1'b1;
                        grant_q <= '0;
                        ptr_q   <= id_q;
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                HDR_SEND, SEND: begin
                    if (i_Tx_Active) begin
                        tx_ready_q <= 1'b0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    // Header leaves last_q clear, so it always continues into LOAD.
                    if (done_rise) begin
                        if (last_q) begin
                            ptr_q   <= id_q;
                            grant_q <= '0;
                            state_q <= IDLE;
                        end else begin
                            state_q <= LOAD;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requesters, a reactive TX controller and a message-level
// round-robin model that predicts the transmitted byte stream together with its owner.
module tb_uart_tx_arbiter;

    localparam int NR = 4;
    localparam int GT = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_byte;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic            tx_ready;
    logic [7:0]      tx_byte;
    logic            tx_active;
    logic            tx_done;
    logic            abort;

    uart_tx_arbiter #(.NUM_REQ(NR), .ADD_HEADER(1), .GAP_TIMEOUT(GT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ack   (req_ack),
        .o_Grant     (grant),
        .o_Tx_Ready  (tx_ready),
        .o_Tx_Byte   (tx_byte),
        .i_Tx_Active (tx_active),
        .i_Tx_Done   (tx_done),
        .o_Abort     (abort)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Requester side: each queue entry is {last, byte}.
    logic [8:0]  rq [NR][$];
    int          hold [NR];
    int          ack_cnt [NR];
    int          data_cnt [NR];
    bit          gap_en = 1'b0;
    bit          abort_ok = 1'b0;
    logic [NR-1:0] ack_s;

    initial begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        for (int r = 0; r < NR; r++) begin
            hold[r] = 0; ack_cnt[r] = 0; data_cnt[r] = 0;
        end
    end

    always begin
        logic [8:0] popped;
        @(negedge clk);
        ack_s = req_ack;
        if (reset_n) begin
            chk("ack_without_valid", 32'(req_ack & ~req_valid), 32'd0);
            chk("ack_onehot", 32'($countones(req_ack) <= 1), 32'd1);
            chk("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (!abort_ok) chk("abort_spurious", 32'(abort), 32'd0);
            for (int r = 0; r < NR; r++) ack_cnt[r] += int'(ack_s[r]);
        end
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (ack_s[r] && rq[r].size() > 0) begin
                popped = rq[r].pop_front();
                if (gap_en && !popped[8]) hold[r] = $urandom_range(0, 4);
            end else if (hold[r] > 0) begin
                hold[r]--;
            end
            req_valid[r]       = (rq[r].size() > 0) && (hold[r] == 0);
            req_byte[8*r +: 8] = (rq[r].size() > 0) ? rq[r][0][7:0] : 8'h00;
            req_last[r]        = (rq[r].size() > 0) ? rq[r][0][8] : 1'b0;
        end
    end

    // TX controller: accepts o_Tx_Ready after a random delay, logs {grant, byte}.
    bit          tx_auto = 1'b0;
    int          tx_done_w = 0;
    int          last_done_cyc = 0;
    logic [11:0] tx_log [$];

    always begin
        logic [7:0] b;
        int w;
        @(posedge clk);
        #1;
        if (tx_auto && tx_ready) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            b = tx_byte;
            tx_log.push_back({grant, b});
            tx_active = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            chk("tx_ready_drop", 32'(tx_ready), 32'd0);
            chk("tx_byte_stable", 32'(tx_byte), 32'(b));
            tx_active     = 1'b0;
            tx_done       = 1'b1;
            last_done_cyc = cyc;
            w = (tx_done_w != 0) ? tx_done_w : $urandom_range(1, 5);
            repeat (w) @(posedge clk);
            #1;
            tx_done = 1'b0;
        end
    end

    // Message-level model: round robin over requesters holding a pending message.
    logic [8:0]  mq [NR][$];
    int          mptr = NR - 1;
    logic [11:0] exp_q [$];

    task automatic add_byte(input int r, input logic [7:0] b, input logic last);
        rq[r].push_back({last, b});
        mq[r].push_back({last, b});
        data_cnt[r]++;
    endtask

    task automatic add_msg(input int r, input int len);
        for (int i = 0; i < len; i++) add_byte(r, 8'($urandom), (i == len - 1));
    endtask

    task automatic build_expect();
        int         idx;
        logic [8:0] e;
        logic [3:0] oh;
        forever begin
            idx = -1;
            for (int k = 1; k <= NR; k++) begin
                if (idx < 0 && mq[(mptr + k) % NR].size() > 0) idx = (mptr + k) % NR;
            end
            if (idx < 0) break;
            oh = 4'(1 << idx);
            exp_q.push_back({oh, 4'hA, 4'(idx)});
            do begin
                e = mq[idx].pop_front();
                exp_q.push_back({oh, e[7:0]});
            end while (!e[8]);
            mptr = idx;
        end
    endtask

    task automatic run_check(input string tag);
        int t;
        t = 0;
        while (tx_log.size() < exp_q.size() && t < 5000) begin
            @(posedge clk);
            #1;
            t++;
        end
        t = 0;
        while ((grant != 0 || tx_active || tx_done) && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
        chk({tag, "_idle_grant"}, 32'(grant), 32'd0);
        for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
            chk($sformatf("%s_tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_q[i]));
        for (int r = 0; r < NR; r++) begin
            chk($sformatf("%s_acks%0d", tag, r), 32'(ack_cnt[r]), 32'(data_cnt[r]));
            chk($sformatf("%s_drained%0d", tag, r), 32'(rq[r].size()), 32'd0);
            ack_cnt[r] = 0;
            data_cnt[r] = 0;
        end
        $display("scenario %s: %0d bytes transmitted", tag, tx_log.size());
        tx_log.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mptr = NR - 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        reset_n   = 1'b0;
        tx_active = 1'b0;
        tx_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ready", 32'(tx_ready), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_ack", 32'(req_ack), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tx_auto = 1'b1;

        // Single message with a 5-cycle done pulse on every byte.
        tx_done_w = 5;
        add_byte(0, 8'h55, 1'b0);
        add_byte(0, 8'hAA, 1'b1);
        build_expect();
        run_check("single");
        tx_done_w = 0;

        // req1 has two messages, req3 one: req3 must get the bus between req1's messages.
        add_msg(1, 3);
        add_msg(1, 2);
        add_msg(3, 2);
        build_expect();
        run_check("rr_stream");

        // From reset, req0 and req2 together: pointer wraps to req0 first.
        do_reset();
        add_msg(0, 2);
        add_msg(2, 3);
        build_expect();
        run_check("pair");

        // Granted requester stalls after one byte: abort after GT cycles in LOAD.
        abort_ok = 1'b1;
        rq[0].push_back({1'b0, 8'h11});
        data_cnt[0] = 1;
        exp_q.push_back({4'b0001, 8'hA0});
        exp_q.push_back({4'b0001, 8'h11});
        t = 0;
        while (!abort && t < 400) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("abort_seen", 32'(abort), 32'd1);
        chk("abort_cycle", 32'(cyc), 32'(last_done_cyc + 1 + GT));
        chk("abort_grant", 32'(grant), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_pulse", 32'(abort), 32'd0);
        mptr = 0;
        run_check("timeout");
        abort_ok = 1'b0;

        // Reset asserted while a byte is in flight clears all outputs immediately.
        tx_auto = 1'b0;
        rq[2].push_back({1'b0, 8'h33});
        rq[2].push_back({1'b1, 8'h44});
        t = 0;
        while (!tx_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("wrst_ready", 32'(tx_ready), 32'd1);
        chk("wrst_hdr", 32'(tx_byte), 32'hA2);
        tx_active = 1'b1;
        @(posedge clk);
        #1;
        chk("wrst_in_wait", 32'({grant, tx_ready}), 32'({4'b0100, 1'b0}));
        #2;
        reset_n = 1'b0;
        #1;
        chk("wrst_grant", 32'(grant), 32'd0);
        chk("wrst_ready0", 32'(tx_ready), 32'd0);
        chk("wrst_byte", 32'(tx_byte), 32'd0);
        chk("wrst_abort", 32'(abort), 32'd0);
        chk("wrst_ack", 32'(req_ack), 32'd0);
        tx_active = 1'b0;
        rq[2].delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mptr = NR - 1;
        @(posedge clk);
        #1;
        tx_auto = 1'b1;

        // Randomized rounds with short mid-message gaps from the granted requester.
        gap_en = 1'b1;
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < NR; r++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int m = 0; m < n; m++) add_msg(r, $urandom_range(1, 4));
            end
            build_expect();
            run_check($sformatf("rand%0d", round));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
